fc1004_io_ports: RTL and testbench

//  Controller/expansion I/O port block. It is the stage that directly drives and samples the
//  PA/PB/PC, JAP, DISK and NTSC pins of the FC1004 top level. It exposes the 68k I/O register

---
 rtl/fc1004_pkg.sv | 72 +++++++
 rtl/fc1004_io_port.sv | 63 ++++++
 rtl/fc1004_io_ports.sv | 143 ++++++++++++++
 tb/tb_fc1004_io_ports.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fc1004_pkg.sv
// FC1004 shared definitions: I/O register window indices,
// reset values and stub read values for the controller port block.
package fc1004_pkg;

    localparam logic [3:0] IO_REG_VERSION = 4'h0;
    localparam logic [3:0] IO_REG_DATA1   = 4'h1;
    localparam logic [3:0] IO_REG_DATA2   = 4'h2;
    localparam logic [3:0] IO_REG_DATA3   = 4'h3;
    localparam logic [3:0] IO_REG_CTRL1   = 4'h4;
    localparam logic [3:0] IO_REG_CTRL2   = 4'h5;
    localparam logic [3:0] IO_REG_CTRL3   = 4'h6;
    localparam logic [3:0] IO_REG_TXD1    = 4'h7;
    localparam logic [3:0] IO_REG_RXD1    = 4'h8;
    localparam logic [3:0] IO_REG_SCTRL1  = 4'h9;
    localparam logic [3:0] IO_REG_TXD2    = 4'hA;
    localparam logic [3:0] IO_REG_RXD2    = 4'hB;
    localparam logic [3:0] IO_REG_SCTRL2  = 4'hC;
    localparam logic [3:0] IO_REG_TXD3    = 4'hD;
    localparam logic [3:0] IO_REG_RXD3    = 4'hE;
    localparam logic [3:0] IO_REG_SCTRL3  = 4'hF;

    localparam logic [7:0] IO_DATA_RESET  = 8'h00;
    localparam logic [7:0] IO_CTRL_RESET  = 8'h00;
    localparam logic [7:0] IO_TXSTUB      = 8'hFF;
    localparam logic [7:0] IO_RXSTUB      = 8'h00;
    localparam logic [7:0] IO_SCTRLSTUB   = 8'h00;

    // Class of a register slot; serial slots are stubs
    typedef enum logic [2:0] {
        IO_KIND_VERSION,
        IO_KIND_DATA,
        IO_KIND_CTRL,
        IO_KIND_TX,
        IO_KIND_RX,
        IO_KIND_SCTRL
    } io_kind_e;

    function automatic io_kind_e io_reg_kind(input logic [3:0] addr);
        io_kind_e k;
        k = IO_KIND_SCTRL;
        unique case (addr)
            IO_REG_VERSION: k = IO_KIND_VERSION;
            IO_REG_DATA1,
            IO_REG_DATA2,
            IO_REG_DATA3:   k = IO_KIND_DATA;
            IO_REG_CTRL1,
            IO_REG_CTRL2,
            IO_REG_CTRL3:   k = IO_KIND_CTRL;
            IO_REG_TXD1,
            IO_REG_TXD2,
            IO_REG_TXD3:    k = IO_KIND_TX;
            IO_REG_RXD1,
            IO_REG_RXD2,
            IO_REG_RXD3:    k = IO_KIND_RX;
            default:        k = IO_KIND_SCTRL;
        endcase
        return k;
    endfunction

    // Fixed value returned by the unimplemented serial slots
    function automatic logic [7:0] io_stub_rdata(input io_kind_e k);
        logic [7:0] v;
        v = IO_SCTRLSTUB;
        if (k == IO_KIND_TX) begin
            v = IO_TXSTUB;
        end else if (k == IO_KIND_RX) begin
            v = IO_RXSTUB;
        end
        return v;
    endfunction

endpackage

// File: rtl/fc1004_io_port.sv
// FC1004 single controller port: data/ctrl registers, pin synchronizer,
// TH edge tracking, read-back mux and interrupt qualifier.
module fc1004_io_port
    import fc1004_pkg::*;
#(
    parameter int SYNC_LEN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_we,
    input  logic       ctrl_we,
    input  logic [7:0] wdata,
    input  logic [6:0] pin_i,
    output logic [6:0] pin_o,
    output logic [6:0] pin_d,
    output logic [7:0] data_rd,
    output logic [7:0] ctrl_rd,
    output logic       irq
);

    logic [7:0] data_q, data_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic [SYNC_LEN-1:0][6:0] sync_q, sync_d;
    logic th_prev_q, th_prev_d;
    logic [6:0] pin_s;

    // Register writes and synchronizer shift
    always_comb begin
        data_d    = data_we ? wdata : data_q;
        ctrl_d    = ctrl_we ? wdata : ctrl_q;
        sync_d    = {sync_q[SYNC_LEN-2:0], pin_i};
        th_prev_d = pin_s[6];
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= IO_DATA_RESET;
            ctrl_q    <= IO_CTRL_RESET;
            sync_q    <= '0;
            th_prev_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            sync_q    <= sync_d;
            th_prev_q <= th_prev_d;
        end
    end

    // Pin drive, read-back mux and armed TH falling-edge detect
    always_comb begin
        pin_s   = sync_q[SYNC_LEN-1];
        pin_o   = data_q[6:0];
        pin_d   = ctrl_q[6:0];
        data_rd = {data_q[7],
                   (data_q[6:0] & ctrl_q[6:0]) |
                   (pin_s & ~ctrl_q[6:0])};
        ctrl_rd = ctrl_q;
        irq     = ctrl_q[7] & ~ctrl_q[6] &
                  th_prev_q & ~pin_s[6];
    end

endmodule

// File: rtl/fc1004_io_ports.sv
// FC1004 I/O port block: $A10000-$A1001F register window, three
// controller ports, strap synchronizers and TH external interrupt.
module fc1004_io_ports
    import fc1004_pkg::*;
#(
    parameter logic [3:0] VERSION  = 4'h0,
    parameter int         SYNC_LEN = 2
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic [3:0] reg_addr,
    input  logic [7:0] reg_wdata,
    input  logic       reg_wr,
    input  logic       reg_rd,
    output logic [7:0] reg_rdata,
    input  logic [6:0] PA_i,
    input  logic [6:0] PB_i,
    input  logic [6:0] PC_i,
    output logic [6:0] PA_o,
    output logic [6:0] PB_o,
    output logic [6:0] PC_o,
    output logic [6:0] PA_d,
    output logic [6:0] PB_d,
    output logic [6:0] PC_d,
    input  logic       JAP_i,
    input  logic       NTSC,
    input  logic       DISK_i,
    output logic       ext_int
);

    logic [2:0] data_we;
    logic [2:0] ctrl_we;
    logic [2:0] port_irq;
    logic [7:0] data_rd [3];
    logic [7:0] ctrl_rd [3];

    logic [7:0] rdata_q, rdata_d;
    logic       ext_int_q, ext_int_d;
    logic [SYNC_LEN-1:0][2:0] strap_q, strap_d;
    logic [2:0] strap_s;
    logic [7:0] version;
    logic [7:0] rd_mux;

    fc1004_io_port #(.SYNC_LEN(SYNC_LEN)) u_port_a (
        .clk     (MCLK),
        .reset   (reset),
        .data_we (data_we[0]),
        .ctrl_we (ctrl_we[0]),
        .wdata   (reg_wdata),
        .pin_i   (PA_i),
        .pin_o   (PA_o),
        .pin_d   (PA_d),
        .data_rd (data_rd[0]),
        .ctrl_rd (ctrl_rd[0]),
        .irq     (port_irq[0])
    );

    fc1004_io_port #(.SYNC_LEN(SYNC_LEN)) u_port_b (
        .clk     (MCLK),
        .reset   (reset),
        .data_we (data_we[1]),
        .ctrl_we (ctrl_we[1]),
        .wdata   (reg_wdata),
        .pin_i   (PB_i),
        .pin_o   (PB_o),
        .pin_d   (PB_d),
        .data_rd (data_rd[1]),
        .ctrl_rd (ctrl_rd[1]),
        .irq     (port_irq[1])
    );

    fc1004_io_port #(.SYNC_LEN(SYNC_LEN)) u_port_c (
        .clk     (MCLK),
        .reset   (reset),
        .data_we (data_we[2]),
        .ctrl_we (ctrl_we[2]),
        .wdata   (reg_wdata),
        .pin_i   (PC_i),
        .pin_o   (PC_o),
        .pin_d   (PC_d),
        .data_rd (data_rd[2]),
        .ctrl_rd (ctrl_rd[2]),
        .irq     (port_irq[2])
    );

    // Write strobe decode; version and serial slots ignore writes
    always_comb begin
        data_we = '0;
        ctrl_we = '0;
        unique case (reg_addr)
            IO_REG_DATA1: data_we[0] = reg_wr;
            IO_REG_DATA2: data_we[1] = reg_wr;
            IO_REG_DATA3: data_we[2] = reg_wr;
            IO_REG_CTRL1: ctrl_we[0] = reg_wr;
            IO_REG_CTRL2: ctrl_we[1] = reg_wr;
            IO_REG_CTRL3: ctrl_we[2] = reg_wr;
            default: ;
        endcase
    end

    // Version byte from synchronized straps {JAP, NTSC, DISK}
    always_comb begin
        strap_d = {strap_q[SYNC_LEN-2:0],
                   {JAP_i, NTSC, DISK_i}};
        strap_s = strap_q[SYNC_LEN-1];
        version = {~strap_s[2], ~strap_s[1],
                   strap_s[0], 1'b0, VERSION};
    end

    // Read mux; data is captured only on a read strobe and then held
    always_comb begin
        rd_mux = io_stub_rdata(io_reg_kind(reg_addr));
        unique case (reg_addr)
            IO_REG_VERSION: rd_mux = version;
            IO_REG_DATA1:   rd_mux = data_rd[0];
            IO_REG_DATA2:   rd_mux = data_rd[1];
            IO_REG_DATA3:   rd_mux = data_rd[2];
            IO_REG_CTRL1:   rd_mux = ctrl_rd[0];
            IO_REG_CTRL2:   rd_mux = ctrl_rd[1];
            IO_REG_CTRL3:   rd_mux = ctrl_rd[2];
            default: ;
        endcase
        rdata_d   = reg_rd ? rd_mux : rdata_q;
        ext_int_d = |port_irq;
    end

    // Read data, interrupt pulse and strap synchronizer registers
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            rdata_q   <= 8'h00;
            ext_int_q <= 1'b0;
            strap_q   <= '0;
        end else begin
            rdata_q   <= rdata_d;
            ext_int_q <= ext_int_d;
            strap_q   <= strap_d;
        end
    end

    assign reg_rdata = rdata_q;
    assign ext_int   = ext_int_q;

endmodule

// File: tb/tb_fc1004_io_ports.sv
// FC1004 I/O port block bench: directed register and pin vectors
// with hand-computed expectations, sampled on the falling clock edge.
module tb_fc1004_io_ports;

    logic       MCLK;
    logic       reset;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic [6:0] PA_i, PB_i, PC_i;
    logic [6:0] PA_o, PB_o, PC_o;
    logic [6:0] PA_d, PB_d, PC_d;
    logic       JAP_i, NTSC, DISK_i;
    logic       ext_int;

    int n_cmp = 0;
    int n_err = 0;

    fc1004_io_ports dut (
        .MCLK      (MCLK),
        .reset     (reset),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .PA_i      (PA_i),
        .PB_i      (PB_i),
        .PC_i      (PC_i),
        .PA_o      (PA_o),
        .PB_o      (PB_o),
        .PC_o      (PC_o),
        .PA_d      (PA_d),
        .PB_d      (PB_d),
        .PC_d      (PC_d),
        .JAP_i     (JAP_i),
        .NTSC      (NTSC),
        .DISK_i    (DISK_i),
        .ext_int   (ext_int)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h want %02h",
                     tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge MCLK);
    endtask

    task automatic wr_reg(input logic [3:0] a,
                          input logic [7:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_wr    = 1'b1;
        tick(1);
        reg_wr    = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a,
                          input logic [7:0] exp,
                          input string tag);
        reg_addr = a;
        reg_rd   = 1'b1;
        tick(1);
        reg_rd   = 1'b0;
        chk(tag, reg_rdata, exp);
    endtask

    logic [7:0] exp_map [16];
    logic       seen;

    initial begin
        reset     = 1'b1;
        reg_addr  = 4'h0;
        reg_wdata = 8'h00;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        PA_i      = 7'h00;
        PB_i      = 7'h00;
        PC_i      = 7'h00;
        JAP_i     = 1'b0;
        NTSC      = 1'b1;
        DISK_i    = 1'b1;

        // Reset state
        tick(2);
        chk("rst_rdata", reg_rdata, 8'h00);
        chk("rst_pa_d", {1'b0, PA_d}, 8'h00);
        chk("rst_pa_o", {1'b0, PA_o}, 8'h00);
        chk("rst_ext_int", {7'b0, ext_int}, 8'h00);
        reset = 1'b0;
        tick(3);

        // 1: full register map after reset
        // version = {~0,~1,1,0,0000} = A0
        exp_map = '{8'hA0, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'hFF,
                    8'h00, 8'h00, 8'hFF, 8'h00,
                    8'h00, 8'hFF, 8'h00, 8'h00};
        for (int a = 0; a < 16; a++) begin
            rd_reg(4'(a), exp_map[a],
                   $sformatf("map_%0h", a));
        end

        // Version write ignored
        wr_reg(4'h0, 8'h5A);
        rd_reg(4'h0, 8'hA0, "ver_wr_ign");
        // TxData stub write ignored
        wr_reg(4'h7, 8'h00);
        rd_reg(4'h7, 8'hFF, "tx_wr_ign");

        // 2: mixed direction on port A
        wr_reg(4'h4, 8'h40);
        wr_reg(4'h1, 8'hC0);
        PA_i = 7'h15;
        chk("pa_d", {1'b0, PA_d}, 8'h40);
        chk("pa_o", {1'b0, PA_o}, 8'h40);
        tick(3);
        // {d7=1, d6=1, pins[5:0]=15} = D5
        rd_reg(4'h1, 8'hD5, "data1_mix");
        rd_reg(4'h4, 8'h40, "ctrl1_rd");

        // 3: armed TH fall on port B
        wr_reg(4'h5, 8'h80);
        PB_i = 7'h40;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            seen |= ext_int;
        end
        chk("pb_rise_arm", {7'b0, seen}, 8'h00);
        PB_i = 7'h00;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            chk($sformatf("pb_fall_c%0d", k),
                {7'b0, ext_int},
                {7'b0, k == 3});
        end
        PB_i = 7'h40;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            seen |= ext_int;
        end
        chk("pb_rise", {7'b0, seen}, 8'h00);

        // 4: TH as output, then disarmed, then late arm
        wr_reg(4'h6, 8'hC0);
        chk("pc_d", {1'b0, PC_d}, 8'h40);
        PC_i = 7'h40;
        tick(4);
        PC_i = 7'h00;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            seen |= ext_int;
        end
        chk("pc_th_out", {7'b0, seen}, 8'h00);
        wr_reg(4'h6, 8'h00);
        PC_i = 7'h40;
        tick(4);
        PC_i = 7'h00;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            seen |= ext_int;
        end
        chk("pc_disarm", {7'b0, seen}, 8'h00);
        wr_reg(4'h6, 8'h80);
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            seen |= ext_int;
        end
        chk("pc_late_arm", {7'b0, seen}, 8'h00);

        // 5: write and read data1 in the same cycle
        reg_addr  = 4'h1;
        reg_wdata = 8'h7F;
        reg_wr    = 1'b1;
        reg_rd    = 1'b1;
        tick(1);
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        chk("rw_same_old", reg_rdata, 8'hD5);
        chk("pa_o_7f", {1'b0, PA_o}, 8'h7F);
        // {d7=0, d6=1, pins[5:0]=15} = 55
        rd_reg(4'h1, 8'h55, "data1_new");
        tick(2);
        chk("rdata_hold", reg_rdata, 8'h55);

        // 6: reset with an interrupt pending
        PB_i = 7'h00;
        tick(2);
        reset = 1'b1;
        #1;
        chk("rr_rdata", reg_rdata, 8'h00);
        chk("rr_pa_o", {1'b0, PA_o}, 8'h00);
        chk("rr_pa_d", {1'b0, PA_d}, 8'h00);
        chk("rr_pb_d", {1'b0, PB_d}, 8'h00);
        chk("rr_ext_int", {7'b0, ext_int}, 8'h00);
        tick(2);
        chk("rr_ext_hold", {7'b0, ext_int}, 8'h00);
        reset = 1'b0;
        tick(3);
        chk("post_rst_int", {7'b0, ext_int}, 8'h00);
        rd_reg(4'h5, 8'h00, "post_rst_ctrl2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
